montpro_seq: RTL and testbench



---
 rtl/montpro_seq_pkg.sv | 19 +
 rtl/montpro_seq_step.sv | 25 ++
 rtl/montpro_seq.sv | 137 +++++++++++++
 tb/tb_montpro_seq.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/montpro_seq_pkg.sv
// Shared definitions for the montpro_seq Montgomery multiplier: FSM state
// encoding, default operand width and the iteration-counter width helper.
package montpro_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ITER = 2'd1,
    ST_SUB  = 2'd2,
    ST_DONE = 2'd3
  } montState_e;

  localparam int MONT_WID_DEFAULT = 256;

  // Counter must be able to hold WID itself (the value after the last step).
  function automatic int cntWidth(input int wid);
    return $clog2(wid + 1);
  endfunction

endpackage

// File: rtl/montpro_seq_step.sv
// One radix-2 Montgomery iteration, purely combinational:
//   s = r + (abit ? b : 0); r_next = (s + (s[0] ? m : 0)) / 2
// With a, b < m and m odd, r stays below 2m, so WID+1 bits hold r and the
// WID+2-bit intermediate cannot overflow.
module montpro_seq_step #(
  parameter int WID = 256
) (
  input  logic [WID:0]   r_i,
  input  logic [WID-1:0] b_i,
  input  logic [WID-1:0] m_i,
  input  logic           abit_i,
  output logic [WID:0]   rNext_o
);

  logic [WID+1:0] partialSum;
  logic [WID+1:0] reducedSum;

  // Add the selected multiplicand, then make the sum even by adding m, then halve.
  always_comb begin
    partialSum = {1'b0, r_i} + (abit_i ? {2'b00, b_i} : '0);
    reducedSum = partialSum + (partialSum[0] ? {2'b00, m_i} : '0);
    rNext_o    = (WID + 1)'(reducedSum >> 1);
  end

endmodule

// File: rtl/montpro_seq.sv
// Sequential radix-2 Montgomery multiplier: r = a*b*2^-WID mod m, fully
// reduced. Start/ready handshake on the input side, valid/ready on the result.
// An even modulus short-circuits straight to DONE with dout=0 and dout_err=1.
module montpro_seq
  import montpro_seq_pkg::*;
#(
  parameter int WID = MONT_WID_DEFAULT
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  output logic           ready,
  input  logic [WID-1:0] a,
  input  logic [WID-1:0] b,
  input  logic [WID-1:0] m,
  output logic           busy,
  output logic [WID-1:0] dout,
  output logic           dout_vld,
  output logic           dout_err,
  input  logic           dout_rdy
);

  localparam int CNTW = cntWidth(WID);
  localparam logic [CNTW-1:0] LAST_ITER = CNTW'(WID - 1);

  montState_e     state_q, state_d;
  logic [WID-1:0] aShift_q, aShift_d;
  logic [WID-1:0] bOp_q, bOp_d;
  logic [WID-1:0] mOp_q, mOp_d;
  logic [WID:0]   acc_q, acc_d;
  logic [CNTW-1:0] cnt_q, cnt_d;
  logic [WID-1:0] dout_q, dout_d;
  logic           err_q, err_d;

  logic [WID:0]   accNext;
  logic           accGeM;
  logic [WID-1:0] accMinusM;

  montpro_seq_step #(
    .WID (WID)
  ) u_step (
    .r_i     (acc_q),
    .b_i     (bOp_q),
    .m_i     (mOp_q),
    .abit_i  (aShift_q[0]),
    .rNext_o (accNext)
  );

  // Final conditional subtraction; low WID bits suffice since the result is < m.
  always_comb begin
    accGeM    = acc_q >= {1'b0, mOp_q};
    accMinusM = acc_q[WID-1:0] - mOp_q;
  end

  // Next-state and datapath updates; every register holds unless its state acts on it.
  always_comb begin
    state_d  = state_q;
    aShift_d = aShift_q;
    bOp_d    = bOp_q;
    mOp_d    = mOp_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    dout_d   = dout_q;
    err_d    = err_q;

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          aShift_d = a;
          bOp_d    = b;
          mOp_d    = m;
          acc_d    = '0;
          cnt_d    = '0;
          if (!m[0]) begin
            dout_d  = '0;
            err_d   = 1'b1;
            state_d = ST_DONE;
          end else begin
            state_d = ST_ITER;
          end
        end
      end
      ST_ITER: begin
        acc_d    = accNext;
        aShift_d = aShift_q >> 1;
        cnt_d    = cnt_q + CNTW'(1);
        if (cnt_q == LAST_ITER) begin
          state_d = ST_SUB;
        end
      end
      ST_SUB: begin
        dout_d  = accGeM ? accMinusM : acc_q[WID-1:0];
        err_d   = 1'b0;
        state_d = ST_DONE;
      end
      ST_DONE: begin
        if (dout_rdy) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers with synchronous reset; reset drops any transaction.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      aShift_q <= '0;
      bOp_q    <= '0;
      mOp_q    <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      dout_q   <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      aShift_q <= aShift_d;
      bOp_q    <= bOp_d;
      mOp_q    <= mOp_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      dout_q   <= dout_d;
      err_q    <= err_d;
    end
  end

  // Handshake outputs decode directly from the state register.
  always_comb begin
    ready    = (state_q == ST_IDLE);
    busy     = ~ready;
    dout_vld = (state_q == ST_DONE);
    dout     = dout_q;
    dout_err = err_q;
  end

endmodule

// File: tb/tb_montpro_seq.sv
// Self-checking bench for montpro_seq: directed table at WID=8, hand-written
// handshake/reset sequences, and random operands at WID=8 and WID=256 checked
// against an arithmetic model (a*b * inverse(2^WID) mod m).
module tb_montpro_seq;

  logic clk = 1'b0;
  logic rst;

  // Narrow instance
  logic       start8, ready8, busy8, vld8, err8, rdy8;
  logic [7:0] a8, b8, m8, dout8;

  // Wide instance
  logic         startW, readyW, busyW, vldW, errW, rdyW;
  logic [255:0] aW, bW, mW, doutW;

  int vecCount  = 0;
  int missCount = 0;
  int subHits   = 0;

  always #5 clk = ~clk;

  montpro_seq #(.WID(8)) dut8 (
    .clk (clk), .rst (rst), .start (start8), .ready (ready8),
    .a (a8), .b (b8), .m (m8), .busy (busy8), .dout (dout8),
    .dout_vld (vld8), .dout_err (err8), .dout_rdy (rdy8)
  );

  montpro_seq #(.WID(256)) dutW (
    .clk (clk), .rst (rst), .start (startW), .ready (readyW),
    .a (aW), .b (bW), .m (mW), .busy (busyW), .dout (doutW),
    .dout_vld (vldW), .dout_err (errW), .dout_rdy (rdyW)
  );

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] m;
    logic [7:0] expDout;
    logic       expErr;
    int         expLat;
  } vec_t;

  vec_t tbl[7];

  task automatic checkOutput(input string name, input logic [255:0] act, input logic [255:0] exp);
    vecCount++;
    if (act !== exp) begin
      missCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Montgomery product at WID=8: fold in inverse(2)^8 mod m.
  function automatic int ref8(input int a, input int b, input int m);
    int invR = 1;
    int half = (m + 1) / 2;
    for (int i = 0; i < 8; i++) invR = (invR * half) % m;
    return ((a * b) % m) * invR % m;
  endfunction

  // True when the unreduced Montgomery result (ab + qm)/2^8 is >= m.
  function automatic bit needsSub8(input int a, input int b, input int m);
    int nInv = 0;
    int q;
    int u;
    for (int x = 0; x < 256; x++) begin
      if (((m * x) & 255) == 255) begin
        nInv = x;
        break;
      end
    end
    q = ((a * b) * nInv) & 255;
    u = (a * b + q * m) >> 8;
    return u >= m;
  endfunction

  function automatic logic [255:0] refW(input logic [255:0] a, input logic [255:0] b, input logic [255:0] m);
    logic [511:0] mm, prod, half, invR, res;
    mm   = {256'b0, m};
    prod = ({256'b0, a} * {256'b0, b}) % mm;
    half = (mm + 512'd1) >> 1;
    invR = 512'd1;
    for (int i = 0; i < 256; i++) invR = (invR * half) % mm;
    res = (prod * invR) % mm;
    return res[255:0];
  endfunction

  function automatic logic [255:0] rand256();
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  // Drive one accepted start on the narrow DUT and wait (bounded) for dout_vld.
  task automatic applyStimulus(input logic [7:0] a, input logic [7:0] b, input logic [7:0] m,
                               output logic [7:0] d, output logic e, output int lat);
    a8 = a; b8 = b; m8 = m; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    lat = 1;
    while (!vld8 && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    d = dout8;
    e = err8;
  endtask

  task automatic applyStimulusWide(input logic [255:0] a, input logic [255:0] b, input logic [255:0] m,
                                   output logic [255:0] d, output logic e, output int lat);
    aW = a; bW = b; mW = m; startW = 1'b1;
    @(posedge clk); #1;
    startW = 1'b0;
    lat = 1;
    while (!vldW && lat < 600) begin
      @(posedge clk); #1;
      lat++;
    end
    d = doutW;
    e = errW;
  endtask

  initial begin
    logic [7:0]   d8;
    logic [255:0] dW, ra, rb, rm;
    logic         e;
    int           lat, ia, ib, im;

    tbl[0] = '{a:8'd5,   b:8'd7,   m:8'd13,  expDout:8'd1,  expErr:1'b0, expLat:10};
    tbl[1] = '{a:8'd12,  b:8'd12,  m:8'd13,  expDout:8'd3,  expErr:1'b0, expLat:10};
    tbl[2] = '{a:8'd9,   b:8'd9,   m:8'd13,  expDout:8'd9,  expErr:1'b0, expLat:10};
    tbl[3] = '{a:8'd12,  b:8'd1,   m:8'd13,  expDout:8'd10, expErr:1'b0, expLat:10};
    tbl[4] = '{a:8'd254, b:8'd254, m:8'd255, expDout:8'd1,  expErr:1'b0, expLat:10};
    tbl[5] = '{a:8'd0,   b:8'd7,   m:8'd13,  expDout:8'd0,  expErr:1'b0, expLat:10};
    tbl[6] = '{a:8'd5,   b:8'd7,   m:8'd12,  expDout:8'd0,  expErr:1'b1, expLat:1};

    rst = 1'b1;
    start8 = 1'b0; rdy8 = 1'b1; a8 = '0; b8 = '0; m8 = '0;
    startW = 1'b0; rdyW = 1'b1; aW = '0; bW = '0; mW = '0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rstReady", 256'(ready8), 256'(1));
    checkOutput("rstBusy",  256'(busy8),  256'(0));
    checkOutput("rstDout",  256'(dout8),  256'(0));
    checkOutput("rstVld",   256'(vld8),   256'(0));
    checkOutput("rstErr",   256'(err8),   256'(0));
    checkOutput("rstReadyW", 256'(readyW), 256'(1));
    checkOutput("rstDoutW",  doutW,        256'(0));
    rst = 1'b0;
    @(posedge clk); #1;

    // Directed table
    for (int i = 0; i < 7; i++) begin
      applyStimulus(tbl[i].a, tbl[i].b, tbl[i].m, d8, e, lat);
      checkOutput("tblDout", 256'(d8),  256'(tbl[i].expDout));
      checkOutput("tblErr",  256'(e),   256'(tbl[i].expErr));
      checkOutput("tblLat",  256'(lat), 256'(tbl[i].expLat));
      checkOutput("tblBusy", 256'(busy8), 256'(1));
      @(posedge clk); #1;
      checkOutput("tblReadyAfter", 256'(ready8), 256'(1));
      checkOutput("tblBusyAfter",  256'(busy8),  256'(0));
      checkOutput("tblVldAfter",   256'(vld8),   256'(0));
    end

    // Backpressure with ignored starts during ITER and DONE
    rdy8 = 1'b0;
    a8 = 8'd5; b8 = 8'd7; m8 = 8'd13; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    a8 = 8'd12; b8 = 8'd12; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    lat = 0;
    while (!vld8 && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    checkOutput("bpVld",  256'(vld8),  256'(1));
    checkOutput("bpDout", 256'(dout8), 256'(1));
    for (int k = 0; k < 5; k++) begin
      if (k == 2) begin
        a8 = 8'd9; b8 = 8'd9; start8 = 1'b1;
      end
      @(posedge clk); #1;
      start8 = 1'b0;
      checkOutput("bpHoldVld",  256'(vld8),  256'(1));
      checkOutput("bpHoldDout", 256'(dout8), 256'(1));
      checkOutput("bpHoldErr",  256'(err8),  256'(0));
    end
    a8 = 8'd12; b8 = 8'd12; start8 = 1'b1; rdy8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    checkOutput("bpRelReady", 256'(ready8), 256'(1));
    checkOutput("bpRelVld",   256'(vld8),   256'(0));
    repeat (14) @(posedge clk);
    #1;
    checkOutput("bpNoSecondVld",  256'(vld8),  256'(0));
    checkOutput("bpDoutKept",     256'(dout8), 256'(1));

    // Reset in the middle of a transaction
    a8 = 8'd12; b8 = 8'd12; m8 = 8'd13; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checkOutput("midRstReady", 256'(ready8), 256'(1));
    checkOutput("midRstVld",   256'(vld8),   256'(0));
    checkOutput("midRstDout",  256'(dout8),  256'(0));
    checkOutput("midRstBusy",  256'(busy8),  256'(0));
    applyStimulus(8'd5, 8'd7, 8'd13, d8, e, lat);
    checkOutput("postRstDout", 256'(d8),  256'(1));
    checkOutput("postRstLat",  256'(lat), 256'(10));
    @(posedge clk); #1;

    // Random narrow operands, weighted towards large moduli
    for (int i = 0; i < 1500; i++) begin
      im = (i % 4 == 0) ? ($urandom_range(1, 63) * 2 + 1) : ($urandom_range(64, 127) * 2 + 1);
      ia = $urandom % im;
      ib = $urandom % im;
      if (needsSub8(ia, ib, im)) subHits++;
      applyStimulus(8'(ia), 8'(ib), 8'(im), d8, e, lat);
      checkOutput("rndDout",  256'(d8), 256'(ref8(ia, ib, im)));
      checkOutput("rndLtM",   256'(int'(d8) < im), 256'(1));
      checkOutput("rndErr",   256'(e), 256'(0));
      checkOutput("rndLat",   256'(lat), 256'(10));
      @(posedge clk); #1;
    end
    checkOutput("subCoverage", 256'(subHits >= 100), 256'(1));

    // Random wide operands
    for (int i = 0; i < 60; i++) begin
      rm = rand256() | 256'd1;
      if (i % 2 == 1) rm[255] = 1'b1;
      ra = rand256() % rm;
      rb = rand256() % rm;
      applyStimulusWide(ra, rb, rm, dW, e, lat);
      checkOutput("wDout", dW, refW(ra, rb, rm));
      checkOutput("wLtM",  256'(dW < rm), 256'(1));
      checkOutput("wErr",  256'(e), 256'(0));
      checkOutput("wLat",  256'(lat), 256'(258));
      @(posedge clk); #1;
      checkOutput("wReadyAfter", 256'(readyW), 256'(1));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

endmodule
